// File: rtl/stopwatch_counter.sv
// Prescaled 100 Hz time base and four-digit BCD stopwatch counter (00.00 .. 59.99).
// The digits advance on every DIV-th clock that samples run=1. tick and wrap pulse in the cycle after an advance.
module stopwatch_counter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clr,
  output logic [15:0] time_bcd,
  output logic        tick,
  output logic        wrap
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] prescale_r;
  logic [15:0]   next_bcd_s;
  logic          rollover_s;
  logic          advance_s;

  // A digit at or above its limit rolls over, so out-of-range values cannot persist.
  always_comb begin
    next_bcd_s = time_bcd;
    rollover_s = 1'b0;
    if (time_bcd[3:0] < 4'd9) begin
      next_bcd_s[3:0] = time_bcd[3:0] + 4'd1;
    end else begin
      next_bcd_s[3:0] = 4'd0;
      if (time_bcd[7:4] < 4'd9) begin
        next_bcd_s[7:4] = time_bcd[7:4] + 4'd1;
      end else begin
        next_bcd_s[7:4] = 4'd0;
        if (time_bcd[11:8] < 4'd9) begin
          next_bcd_s[11:8] = time_bcd[11:8] + 4'd1;
        end else begin
          next_bcd_s[11:8] = 4'd0;
          if (time_bcd[15:12] < 4'd5) begin
            next_bcd_s[15:12] = time_bcd[15:12] + 4'd1;
          end else begin
            next_bcd_s[15:12] = 4'd0;
            rollover_s        = 1'b1;
          end
        end
      end
    end
  end

  assign advance_s = run && (prescale_r == PRE_LAST);

  // Prescaler, digit registers and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_r <= '0;
      time_bcd   <= 16'h0000;
      tick       <= 1'b0;
      wrap       <= 1'b0;
    end else if (clr) begin
      prescale_r <= '0;
      time_bcd   <= 16'h0000;
      tick       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      tick <= advance_s;
      wrap <= advance_s && rollover_s;
      if (advance_s) begin
        prescale_r <= '0;
        time_bcd   <= next_bcd_s;
      end else if (run) begin
        prescale_r <= prescale_r + PW'(1);
      end else begin
        prescale_r <= prescale_r;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomised and directed bench for stopwatch_counter with DIV=4.
// The reference model counts run edges and centiseconds as plain integers.
module tb_stopwatch_counter;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        clr;
  logic [15:0] time_bcd;
  logic        tick;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  // Reference model: run-edges since the last advance, and elapsed centiseconds.
  int   m_phase = 0;
  int   m_cs    = 0;
  logic m_tick  = 1'b0;
  logic m_wrap  = 1'b0;

  stopwatch_counter #(.CLK_FREQ(400), .TICK_HZ(100)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .clr      (clr),
    .time_bcd (time_bcd),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    int s;
    int c;
    s = n / 100;
    c = n % 100;
    return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic step(input logic r, input logic c, input logic rn);
    reset = r;
    clr   = c;
    run   = rn;
    @(posedge clk);
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (r || c) begin
      m_phase = 0;
      m_cs    = 0;
    end else if (rn) begin
      m_phase++;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_cs    = (m_cs + 1) % 6000;
        m_tick  = 1'b1;
        m_wrap  = (m_cs == 0);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (time_bcd !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: time=%h tick=%b wrap=%b, expected 0000/0/0", time_bcd, tick, wrap);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (time_bcd !== 16'h0000 || tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_latency edge %0d: time=%h tick=%b, expected 0000/0", i, time_bcd, tick);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_bcd !== 16'h0001 || tick !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_inc: time=%h tick=%b wrap=%b, expected 0001/1/0", time_bcd, tick, wrap);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick_width: tick=%b, expected 0", tick);
    end
  endtask

  task automatic test_count();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 400; e++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (time_bcd !== to_bcd(m_cs) || tick !== m_tick || wrap !== m_wrap) begin
        errors++;
        $display("FAIL count edge %0d: time=%h tick=%b wrap=%b, expected %h/%b/%b",
                 e, time_bcd, tick, wrap, to_bcd(m_cs), m_tick, m_wrap);
      end
      if (e == 4 || e == 40 || e == 400) begin
        checks++;
        if (time_bcd !== ((e == 4) ? 16'h0001 : (e == 40) ? 16'h0010 : 16'h0100)) begin
          errors++;
          $display("FAIL count_milestone edge %0d: time=%h", e, time_bcd);
        end
      end
    end
  endtask

  task automatic test_pause();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (time_bcd !== 16'h0000 || tick !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold: time=%h tick=%b, expected 0000/0", time_bcd, tick);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL pause_resume1: time=%h, expected 0000", time_bcd);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_bcd !== 16'h0001 || tick !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume2: time=%h tick=%b, expected 0001/1", time_bcd, tick);
    end
  endtask

  task automatic test_wrap();
    int wraps;
    wraps = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 23996; e++) begin
      step(1'b0, 1'b0, 1'b1);
      if (wrap === 1'b1) wraps++;
    end
    checks++;
    if (time_bcd !== 16'h5999 || wraps != 0) begin
      errors++;
      $display("FAIL wrap_5999: time=%h early_wraps=%0d, expected 5999/0", time_bcd, wraps);
    end
    for (int e = 0; e < 4; e++) step(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_bcd !== 16'h0000 || wrap !== 1'b1 || tick !== 1'b1 || m_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_rollover: time=%h wrap=%b tick=%b, expected 0000/1/1", time_bcd, wrap, tick);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (wrap !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL wrap_width: wrap=%b tick=%b, expected 0/0", wrap, tick);
    end
  endtask

  task automatic test_clr();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 123 * DIV; e++) step(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_bcd !== 16'h0123) begin
      errors++;
      $display("FAIL clr_setup: time=%h, expected 0123", time_bcd);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (time_bcd !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL clr_clear: time=%h tick=%b wrap=%b, expected 0000/0/0", time_bcd, tick, wrap);
    end
    for (int e = 1; e <= 4; e++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (time_bcd !== ((e == 4) ? 16'h0001 : 16'h0000)) begin
        errors++;
        $display("FAIL clr_restart edge %0d: time=%h", e, time_bcd);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 3; e++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (time_bcd !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL simul_reset_clr: time=%h tick=%b wrap=%b, expected 0000/0/0", time_bcd, tick, wrap);
    end
    for (int e = 0; e < 3; e++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (time_bcd !== 16'h0000 || tick !== 1'b0) begin
      errors++;
      $display("FAIL simul_clr_at_last: time=%h tick=%b, expected 0000/0", time_bcd, tick);
    end
    for (int e = 0; e < 3; e++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (time_bcd !== 16'h0000 || tick !== 1'b0) begin
      errors++;
      $display("FAIL simul_run_drop: time=%h tick=%b, expected 0000/0", time_bcd, tick);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (time_bcd !== 16'h0001 || tick !== 1'b1) begin
      errors++;
      $display("FAIL simul_resume: time=%h tick=%b, expected 0001/1", time_bcd, tick);
    end
  endtask

  task automatic test_random();
    logic r;
    logic c;
    logic rn;
    step(1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 3000; e++) begin
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 3) != 0);
      step(r, c, rn);
      checks++;
      if (time_bcd !== to_bcd(m_cs) || tick !== m_tick || wrap !== m_wrap) begin
        errors++;
        $display("FAIL random edge %0d: time=%h tick=%b wrap=%b, expected %h/%b/%b",
                 e, time_bcd, tick, wrap, to_bcd(m_cs), m_tick, m_wrap);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clr   = 1'b0;
    run   = 1'b1;
    test_reset();
    test_count();
    test_pause();
    test_wrap();
    test_clr();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
